// File: rtl/ec3_pkg.sv
// rtl/ec3_pkg.sv - ISA constants and FSM state encoding for the ec3 accumulator core
// Purpose : opcode width, the sixteen opcode values and the control state enum,
//           shared by the core, its memory and its bus interface.
// Ports   : none (package).
package ec3_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_LDA  = 4'd0;
  localparam logic [OP_W-1:0] OP_STA  = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
  localparam logic [OP_W-1:0] OP_IN   = 4'd4;
  localparam logic [OP_W-1:0] OP_JZ   = 4'd5;
  localparam logic [OP_W-1:0] OP_JPOS = 4'd6;
  localparam logic [OP_W-1:0] OP_HALT = 4'd7;
  localparam logic [OP_W-1:0] OP_AND  = 4'd8;
  localparam logic [OP_W-1:0] OP_OR   = 4'd9;
  localparam logic [OP_W-1:0] OP_JMP  = 4'd10;
  localparam logic [OP_W-1:0] OP_OUT  = 4'd11;
  localparam logic [OP_W-1:0] OP_JC   = 4'd12;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd13;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd14;
  localparam logic [OP_W-1:0] OP_NOP  = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_IN,
    S_HALT
  } state_t;

endpackage

// File: rtl/ec3_if.sv
// rtl/ec3_if.sv - external bus of the ec3 core: Enter/Input handshake, program load, output
// Purpose : bundles every non-clock, non-reset signal of the core.
// Signals : enter, in_data           - pushbutton and operand for IN
//           load_en/load_addr/load_data - program-load write port
//           out_data, out_valid      - OUT register and its one-cycle strobe
//           halt, wait_in            - status flags
// Modports: master (environment side), slave (core side).
interface ec3_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
);
  import ec3_pkg::*;

  logic              enter;
  logic [DATA_W-1:0] in_data;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halt;
  logic              wait_in;

  modport master (
    output enter, in_data, load_en, load_addr, load_data,
    input  out_data, out_valid, halt, wait_in
  );

  modport slave (
    input  enter, in_data, load_en, load_addr, load_data,
    output out_data, out_valid, halt, wait_in
  );

endinterface

// File: rtl/ec3_memory.sv
// rtl/ec3_memory.sv - unified instruction/data store, asynchronous read, synchronous write
// Purpose : 2**ADDR_W x DATA_W array; contents are deliberately not reset.
// Ports   : clk           - write clock
//           we/waddr/wdata - single write port (muxed by the core)
//           raddr/rdata    - combinational read port
module ec3_memory #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ec3_microprocessor.sv
// rtl/ec3_microprocessor.sv - ec3 accumulator core: fetch/decode/exec FSM, datapath, Enter sync
// Purpose : 16-opcode accumulator machine with carry, OUT strobe and an
//           edge-detected, synchronised Enter handshake for IN.
// Ports   : clk - system clock, rising edge
//           rst - asynchronous active-high reset
//           bus - ec3_if.slave (enter, in_data, load_*, out_data, out_valid, halt, wait_in)
module ec3_microprocessor
  import ec3_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
) (
  input logic  clk,
  input logic  rst,
  ec3_if.slave bus
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic              c;
  logic [DATA_W-1:0] out_r;
  logic              out_valid_r;
  logic              halt_r;
  logic              wait_in_r;

  // Enter synchroniser; all three flops reset high so a button held through
  // reset cannot look like a fresh press.
  logic enter_s1, enter_s2, enter_prev;
  logic enter_edge;

  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] m;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   sub_sum;
  logic              unused_ir;

  assign op         = ir[DATA_W-1 -: OP_W];
  assign m          = ir[ADDR_W-1:0];
  assign unused_ir  = ^ir;  // middle instruction bits carry no meaning
  assign enter_edge = enter_s2 & ~enter_prev;

  // One read port: PC during fetch, operand address otherwise.
  assign mem_raddr = (state == S_FETCH) ? pc : m;

  // Write port: core store at the EXEC edge, else the load port, which is only
  // honoured while the core is held in reset or parked in S_HALT.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = m;
    mem_wdata = a;
    if (state == S_EXEC && op == OP_STA) begin
      mem_we = 1'b1;
    end else if (bus.load_en && (rst || state == S_HALT)) begin
      mem_we    = 1'b1;
      mem_waddr = bus.load_addr;
      mem_wdata = bus.load_data;
    end
  end

  ec3_memory #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Carry-out of the extra MSB; for SUB a set carry means no borrow.
  assign add_sum = {1'b0, a} + {1'b0, mem_rdata};
  assign sub_sum = {1'b0, a} + {1'b0, ~mem_rdata} + {{DATA_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= '0;
      ir          <= '0;
      a           <= '0;
      c           <= 1'b0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      halt_r      <= 1'b0;
      wait_in_r   <= 1'b0;
      enter_s1    <= 1'b1;
      enter_s2    <= 1'b1;
      enter_prev  <= 1'b1;
    end else begin
      enter_s1    <= bus.enter;
      enter_s2    <= enter_s1;
      enter_prev  <= enter_s2;
      out_valid_r <= 1'b0;
      case (state)
        S_FETCH: begin
          ir    <= mem_rdata;
          pc    <= pc + ADDR_W'(1);
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (op == OP_IN) begin
            state     <= S_WAIT_IN;
            wait_in_r <= 1'b1;
          end else if (op == OP_HALT) begin
            state  <= S_HALT;
            halt_r <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
          case (op)
            OP_LDA:  a <= mem_rdata;
            OP_ADD:  {c, a} <= add_sum;
            OP_SUB:  {c, a} <= sub_sum;
            OP_JZ:   if (a == '0) pc <= m;
            OP_JPOS: if (!a[DATA_W-1] && a != '0) pc <= m;
            OP_AND:  a <= a & mem_rdata;
            OP_OR:   a <= a | mem_rdata;
            OP_JMP:  pc <= m;
            OP_OUT: begin
              out_r       <= a;
              out_valid_r <= 1'b1;
            end
            OP_JC:   if (c) pc <= m;
            OP_SHL: begin
              c <= a[DATA_W-1];
              a <= {a[DATA_W-2:0], 1'b0};
            end
            OP_SHR: begin
              c <= a[0];
              a <= {1'b0, a[DATA_W-1:1]};
            end
            default: ;  // STA commits through the memory write port; NOP
          endcase
        end
        S_WAIT_IN: begin
          // Edges seen in any other state are simply dropped.
          if (enter_edge) begin
            a         <= bus.in_data;
            wait_in_r <= 1'b0;
            state     <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign bus.out_data  = out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.halt      = halt_r;
  assign bus.wait_in   = wait_in_r;

endmodule

// File: tb/tb_ec3_microprocessor.sv
// tb/tb_ec3_microprocessor.sv - self-checking bench for ec3_microprocessor
module tb_ec3_microprocessor;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;

  always #5 clk = ~clk;

  ec3_if #(.DATA_W(12), .ADDR_W(8)) b ();
  ec3_if #(.DATA_W(8),  .ADDR_W(4)) bs ();

  ec3_microprocessor #(.DATA_W(12), .ADDR_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  ec3_microprocessor #(.DATA_W(8), .ADDR_W(4)) u_dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (bs)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int img[256];
  int inq[$];
  int exp_q[$];
  bit exp_halt;
  int exp_steps;
  int got_q[$];
  int got_t[$];
  int got_s[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && b.out_valid) begin
      got_q.push_back(int'(b.out_data));
      got_t.push_back(cyc);
    end
    if (!rst_s && bs.out_valid) got_s.push_back(int'(bs.out_data));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction-level ISA model over img[] and inq[].
  task automatic model(input int dw, input int aw);
    int mm[256];
    int pc, a, c, ir, op, m, mask, amask, k, s;
    bit stuck;
    mask  = (1 << dw) - 1;
    amask = (1 << aw) - 1;
    for (int i = 0; i < 256; i++) mm[i] = img[i];
    pc = 0; a = 0; c = 0; k = 0; stuck = 0;
    exp_q.delete();
    exp_halt  = 0;
    exp_steps = 0;
    while (!exp_halt && !stuck && exp_steps < 4000) begin
      ir = mm[pc];
      pc = (pc + 1) & amask;
      op = (ir >> (dw - 4)) & 15;
      m  = ir & amask;
      exp_steps++;
      case (op)
        0:  a = mm[m];
        1:  mm[m] = a;
        2:  begin s = a + mm[m]; c = (s >> dw) & 1; a = s & mask; end
        3:  begin s = a + ((~mm[m]) & mask) + 1; c = (s >> dw) & 1; a = s & mask; end
        4:  if (k < inq.size()) begin a = inq[k]; k++; end else stuck = 1;
        5:  if (a == 0) pc = m;
        6:  if (a != 0 && a < (1 << (dw - 1))) pc = m;
        7:  exp_halt = 1;
        8:  a = a & mm[m];
        9:  a = a | mm[m];
        10: pc = m;
        11: exp_q.push_back(a);
        12: if (c != 0) pc = m;
        13: begin c = (a >> (dw - 1)) & 1; a = (a << 1) & mask; end
        14: begin c = a & 1; a = a >> 1; end
        default: ;
      endcase
    end
  endtask

  function automatic int ins(input int op, input int m);
    return (op << 8) | m;
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 0;
    inq.delete();
  endtask

  task automatic load_main();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      b.load_en   = 1'b1;
      b.load_addr = 8'(i);
      b.load_data = 12'(img[i]);
    end
    @(negedge clk);
    b.load_en = 1'b0;
  endtask

  task automatic run_test(input string name, input bit do_load, input bit rogue);
    int k, hi, lo, t, budget, n;
    model(12, 8);
    budget = exp_steps * 3 + inq.size() * 12 + 40;
    if (do_load) load_main();
    else begin
      rst = 1'b1;
      @(negedge clk);
    end
    got_q.delete();
    got_t.delete();
    b.enter = 1'b0;
    k = 0; hi = 0; lo = 0; t = 0;
    @(negedge clk);
    rst = 1'b0;
    while (!b.halt && t < budget) begin
      @(negedge clk);
      t++;
      b.load_en   = rogue && t >= 2 && t < 14;
      b.load_addr = 8'h40;
      b.load_data = 12'h5A5;
      if (b.enter) begin
        hi++;
        if (hi == 2) check({name, ":wait_hold"}, b.wait_in, 1);
        if (hi == 3) begin
          check({name, ":wait_drop"}, b.wait_in, 0);
          b.enter = 1'b0;
          lo = 0;
        end
      end else begin
        lo++;
        if (b.wait_in && lo >= 4 && k < inq.size()) begin
          b.in_data = 12'(inq[k]);
          k++;
          b.enter = 1'b1;
          hi = 0;
        end
      end
    end
    b.load_en = 1'b0;
    check({name, ":halt"}, b.halt, exp_halt);
    check({name, ":wait_in"}, b.wait_in, 0);
    check({name, ":n_out"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s:out%0d", name, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    rst = 1'b1;
    rst_s = 1'b1;
    b.enter = 1'b0; b.in_data = '0; b.load_en = 1'b0; b.load_addr = '0; b.load_data = '0;
    bs.enter = 1'b0; bs.in_data = '0; bs.load_en = 1'b0; bs.load_addr = '0; bs.load_data = '0;
    repeat (2) @(negedge clk);
    check("rst:out_data", b.out_data, 0);
    check("rst:out_valid", b.out_valid, 0);
    check("rst:halt", b.halt, 0);
    check("rst:wait_in", b.wait_in, 0);

    // Add: IN; STA 0x10; IN; ADD 0x10; OUT; HALT with 5 and 7
    clear_img();
    img[0] = ins(4, 0); img[1] = ins(1, 16'h10); img[2] = ins(4, 0);
    img[3] = ins(2, 16'h10); img[4] = ins(11, 0); img[5] = ins(7, 0);
    inq.push_back(5); inq.push_back(7);
    run_test("add", 1, 0);
    check("add:value", (got_q.size() == 1) ? got_q[0] : 32'hDEAD, 12);

    // Carry out of 0xFFF + 1 taken by JC
    clear_img();
    img[8'h20] = 12'hFFF; img[8'h21] = 1;
    img[0] = ins(0, 8'h20); img[1] = ins(2, 8'h21); img[2] = ins(12, 8'h08);
    img[3] = ins(7, 0); img[8] = ins(11, 0); img[9] = ins(7, 0);
    run_test("carry_add", 1, 0);
    check("carry_add:taken", got_q.size(), 1);

    // 5-5: no borrow, JC taken
    clear_img();
    img[8'h22] = 5;
    img[0] = ins(0, 8'h22); img[1] = ins(3, 8'h22); img[2] = ins(12, 5);
    img[3] = ins(7, 0); img[5] = ins(11, 0); img[6] = ins(7, 0);
    run_test("sub_eq", 1, 0);

    // 3-5: borrow, A=0xFFE, JC not taken
    clear_img();
    img[8'h22] = 5; img[8'h23] = 3; img[8'h24] = 12'h123;
    img[0] = ins(0, 8'h23); img[1] = ins(3, 8'h22); img[2] = ins(11, 0);
    img[3] = ins(12, 6); img[4] = ins(0, 8'h24); img[5] = ins(11, 0); img[6] = ins(7, 0);
    run_test("sub_lt", 1, 0);
    check("sub_lt:diff", (got_q.size() > 0) ? got_q[0] : 32'hDEAD, 12'hFFE);

    // Countdown 3 -> 2,1,0 with a 4-instruction loop
    clear_img();
    img[8'h30] = 1; img[8'h31] = 3;
    img[0] = ins(0, 8'h31); img[1] = ins(3, 8'h30); img[2] = ins(11, 0);
    img[3] = ins(15, 0); img[4] = ins(6, 1); img[5] = ins(7, 0);
    run_test("count", 1, 0);
    check("count:period", (got_t.size() >= 2) ? got_t[1] - got_t[0] : -1, 12);

    // LoadEn while running is ignored; LoadEn while halted writes
    clear_img();
    for (int i = 0; i < 6; i++) img[i] = ins(15, 0);
    img[6] = ins(0, 8'h40); img[7] = ins(11, 0); img[8] = ins(7, 0); img[8'h40] = 12'h123;
    run_test("load_run", 1, 1);
    @(negedge clk);
    b.load_en = 1'b1; b.load_addr = 8'h40; b.load_data = 12'h777;
    @(negedge clk);
    b.load_en = 1'b0;
    img[8'h40] = 12'h777;
    run_test("load_halt", 0, 0);

    // Enter discipline: IN; OUT; NOP; IN; OUT; IN; OUT; HALT
    clear_img();
    img[0] = ins(4, 0); img[1] = ins(11, 0); img[2] = ins(15, 0); img[3] = ins(4, 0);
    img[4] = ins(11, 0); img[5] = ins(4, 0); img[6] = ins(11, 0); img[7] = ins(7, 0);
    b.enter = 1'b1;
    load_main();
    got_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("held_rst:wait", b.wait_in, 1);
    check("held_rst:n_out", got_q.size(), 0);
    b.enter = 1'b0;
    repeat (4) @(negedge clk);
    b.in_data = 12'h111; b.enter = 1'b1;
    repeat (3) @(negedge clk);
    b.enter = 1'b0;
    repeat (3) @(negedge clk);
    b.enter = 1'b1;
    @(negedge clk);
    b.enter = 1'b0;
    repeat (10) @(negedge clk);
    check("exec_pulse:wait", b.wait_in, 1);
    check("exec_pulse:n_out", got_q.size(), 1);
    check("exec_pulse:val", (got_q.size() > 0) ? got_q[0] : 32'hDEAD, 12'h111);
    b.in_data = 12'h222; b.enter = 1'b1;
    repeat (20) @(negedge clk);
    check("held20:n_out", got_q.size(), 2);
    check("held20:wait", b.wait_in, 1);
    check("held20:out_data", b.out_data, 12'h222);
    #2 rst = 1'b1;
    #1;
    check("async_rst:out_data", b.out_data, 0);
    check("async_rst:wait_in", b.wait_in, 0);
    check("async_rst:halt", b.halt, 0);
    check("async_rst:out_valid", b.out_valid, 0);
    b.enter = 1'b0;

    // Randomised forward-only programs that always reach HALT
    for (int r = 0; r < 20; r++) begin
      int len, op, mo;
      clear_img();
      for (int i = 0; i < 16; i++) img[128 + i] = int'($urandom_range(0, 4095));
      len = int'($urandom_range(6, 40));
      for (int i = 0; i < len - 1; i++) begin
        op = int'($urandom_range(0, 15));
        if (op == 5 || op == 6 || op == 10 || op == 12) mo = int'($urandom_range(i + 1, len - 1));
        else if (op <= 3 && op != 4 || op == 8 || op == 9) mo = 128 + int'($urandom_range(0, 15));
        else mo = int'($urandom_range(0, 255));
        img[i] = ins(op, mo);
      end
      img[len - 1] = ins(7, int'($urandom_range(0, 255)));
      for (int i = 0; i < 64; i++) inq.push_back(int'($urandom_range(0, 4095)));
      run_test($sformatf("rnd%0d", r), 1, 0);
    end

    // Narrow core: PC wrap through NOP at 15, SHL 0x80 and SHR 0x01 set carry
    clear_img();
    img[0] = 8'hC5; img[1] = 8'h0D; img[2] = 8'hD0; img[3] = 8'hB0;
    img[4] = 8'hAE; img[5] = 8'h0C; img[6] = 8'hB0; img[7] = 8'hE0;
    img[8] = 8'hCA; img[9] = 8'h70; img[10] = 8'hB0; img[11] = 8'h70;
    img[12] = 8'h01; img[13] = 8'h80; img[14] = 8'hF0; img[15] = 8'hF0;
    model(8, 4);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bs.load_en = 1'b1; bs.load_addr = 4'(i); bs.load_data = 8'(img[i]);
    end
    @(negedge clk);
    bs.load_en = 1'b0;
    got_s.delete();
    @(negedge clk);
    rst_s = 1'b0;
    for (int t = 0; t < exp_steps * 3 + 20 && !bs.halt; t++) @(negedge clk);
    check("narrow:halt", bs.halt, exp_halt);
    check("narrow:n_out", got_s.size(), exp_q.size());
    check("narrow:n_const", got_s.size(), 3);
    check("narrow:wrap_out", (got_s.size() > 1) ? got_s[1] : 32'hDEAD, 1);
    for (int i = 0; i < got_s.size() && i < exp_q.size(); i++)
      check($sformatf("narrow:out%0d", i), got_s[i], exp_q[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
